// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch stage and the stage-0/1 pipeline register.
package pipe_pkg;

  localparam int unsigned PIPE_PC_W    = 8;
  localparam int unsigned PIPE_INSTR_W = 26;
  localparam int unsigned FW_W         = PIPE_PC_W + PIPE_INSTR_W;
  localparam int unsigned FW_PC_LSB    = PIPE_INSTR_W;
  localparam int unsigned FW_INSTR_LSB = 0;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous clear to RESET_PC, redirect load, and wrap-around increment.
module pc_counter #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (clr)       pc <= RESET_PC;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory,
// buffers one word under downstream stall and discards wrong-path fetches on redirect.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned     PC_W     = PIPE_PC_W,
  parameter int unsigned     INSTR_W  = PIPE_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    clr,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_data,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic [PC_W+INSTR_W-1:0] fw_word,
  output logic                    fw_valid,
  output logic [PC_W-1:0]         pc
);

  fetch_state_t               state;
  logic [PC_W+INSTR_W-1:0]    hold;
  logic [PC_W-1:0]            drain_addr;
  logic                       pc_inc;

  assign pc_inc = (state == FETCH) && imem_ack && !redirect;

  pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .clr      (clr),
    .load     (redirect),
    .load_val (redirect_pc),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // While draining, pc already points at the new path; the request keeps the old address.
  assign imem_req  = !clr && (state != HOLD);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= FETCH;
      fw_valid   <= 1'b0;
      fw_word    <= '0;
      hold       <= '0;
      drain_addr <= '0;
    end else begin
      fw_valid <= 1'b0;
      if (redirect) begin
        case (state)
          FETCH: if (!imem_ack) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
          HOLD: begin
            state <= FETCH;
            hold  <= '0;
          end
          DRAIN:   if (imem_ack) state <= FETCH;
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: if (imem_ack) begin
            if (stall) begin
              hold  <= {pc, imem_data};
              state <= HOLD;
            end else begin
              fw_word  <= {pc, imem_data};
              fw_valid <= 1'b1;
            end
          end
          HOLD: if (!stall) begin
            fw_word  <= hold;
            fw_valid <= 1'b1;
            state    <= FETCH;
          end
          DRAIN:   if (imem_ack) state <= FETCH;
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written reset
// corner cases, and randomized traffic against a scoreboard model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        clr, imem_req, imem_ack, stall, redirect, fw_valid;
  logic [7:0]  imem_addr, redirect_pc, pc;
  logic [25:0] imem_data;
  logic [33:0] fw_word;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(.PC_W(8), .INSTR_W(26), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .clr         (clr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fw_word     (fw_word),
    .fw_valid    (fw_valid),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] mem(input logic [7:0] a);
    return {18'd0, a} * 26'd3;
  endfunction

  function automatic logic [33:0] word(input logic [7:0] a);
    return {a, mem(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic a, input logic s, input logic r,
                       input logic [7:0] rpc, input logic [7:0] daddr);
    clr = c; imem_ack = a; stall = s; redirect = r; redirect_pc = rpc;
    imem_data = a ? mem(daddr) : 26'h3ffffff;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       clr, ack, stall, redir;
    logic [7:0] rpc;
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] wpc;
    logic [7:0] pc_after;
  } vec_t;

  function automatic vec_t mk(input logic c, a, s, r, input logic [7:0] rpc,
                              input logic q, input logic [7:0] ad,
                              input logic v, input logic [7:0] wp, input logic [7:0] pa);
    vec_t t;
    t.clr = c; t.ack = a; t.stall = s; t.redir = r; t.rpc = rpc;
    t.req = q; t.addr = ad; t.valid = v; t.wpc = wp; t.pc_after = pa;
    return t;
  endfunction

  vec_t vecs [27];

  // Scoreboard model state
  logic        m_held, m_drain, e_valid, e_req, a, s, r;
  logic [7:0]  m_pc, m_daddr, e_addr, rp;
  logic [33:0] m_hword, e_word, w;

  initial begin
    //             clr ack stl red rpc    req addr   vld wpc    pc
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    vecs[1]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h00, 1, 8'h00, 8'h01);
    vecs[2]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h01, 1, 8'h01, 8'h02);
    vecs[3]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h02, 1, 8'h02, 8'h03);
    vecs[4]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h03, 1, 8'h03, 8'h04);
    vecs[5]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h04, 1, 8'h04, 8'h05);
    vecs[6]  = mk(0, 1, 1, 0, 8'h00, 1, 8'h05, 0, 8'h00, 8'h06);
    vecs[7]  = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h06);
    vecs[8]  = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h06);
    vecs[9]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h05, 8'h06);
    vecs[10] = mk(0, 0, 0, 0, 8'h00, 1, 8'h06, 0, 8'h00, 8'h06);
    vecs[11] = mk(0, 1, 0, 0, 8'h00, 1, 8'h06, 1, 8'h06, 8'h07);
    vecs[12] = mk(0, 0, 0, 1, 8'h10, 1, 8'h07, 0, 8'h00, 8'h10);
    vecs[13] = mk(0, 1, 0, 0, 8'h00, 1, 8'h07, 0, 8'h00, 8'h10);
    vecs[14] = mk(0, 0, 0, 1, 8'h40, 1, 8'h10, 0, 8'h00, 8'h40);
    vecs[15] = mk(0, 0, 0, 0, 8'h00, 1, 8'h10, 0, 8'h00, 8'h40);
    vecs[16] = mk(0, 1, 0, 0, 8'h00, 1, 8'h10, 0, 8'h00, 8'h40);
    vecs[17] = mk(0, 1, 0, 0, 8'h00, 1, 8'h40, 1, 8'h40, 8'h41);
    vecs[18] = mk(0, 1, 0, 1, 8'h22, 1, 8'h41, 0, 8'h00, 8'h22);
    vecs[19] = mk(0, 1, 0, 1, 8'h80, 1, 8'h22, 0, 8'h00, 8'h80);
    vecs[20] = mk(0, 1, 0, 0, 8'h00, 1, 8'h80, 1, 8'h80, 8'h81);
    vecs[21] = mk(0, 1, 0, 1, 8'hFF, 1, 8'h81, 0, 8'h00, 8'hFF);
    vecs[22] = mk(0, 1, 0, 0, 8'h00, 1, 8'hFF, 1, 8'hFF, 8'h00);
    vecs[23] = mk(0, 1, 0, 0, 8'h00, 1, 8'h00, 1, 8'h00, 8'h01);
    vecs[24] = mk(0, 1, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 8'h02);
    vecs[25] = mk(0, 0, 0, 1, 8'h30, 0, 8'h00, 0, 8'h00, 8'h30);
    vecs[26] = mk(0, 1, 0, 0, 8'h00, 1, 8'h30, 1, 8'h30, 8'h31);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].clr, vecs[i].ack, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].addr);
      #1;
      chk($sformatf("v%0d imem_req", i), 64'(imem_req), 64'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d imem_addr", i), 64'(imem_addr), 64'(vecs[i].addr));
      step();
      chk($sformatf("v%0d fw_valid", i), 64'(fw_valid), 64'(vecs[i].valid));
      if (vecs[i].valid) chk($sformatf("v%0d fw_word", i), 64'(fw_word), 64'(word(vecs[i].wpc)));
      if (vecs[i].clr)   chk($sformatf("v%0d fw_word_rst", i), 64'(fw_word), 64'd0);
      chk($sformatf("v%0d pc", i), 64'(pc), 64'(vecs[i].pc_after));
    end

    // Reset while a word is parked in the hold buffer
    drive(0, 1, 1, 0, 8'h00, 8'h31); step();
    chk("hold_entry fw_valid", 64'(fw_valid), 64'd0);
    drive(1, 0, 0, 0, 8'h00, 8'h00); #1;
    chk("hold_clr imem_req", 64'(imem_req), 64'd0);
    step();
    chk("hold_clr pc", 64'(pc), 64'd0);
    chk("hold_clr fw_valid", 64'(fw_valid), 64'd0);
    chk("hold_clr fw_word", 64'(fw_word), 64'd0);
    drive(0, 0, 0, 0, 8'h00, 8'h00); #1;
    chk("hold_after imem_req", 64'(imem_req), 64'd1);
    chk("hold_after imem_addr", 64'(imem_addr), 64'd0);
    step();
    chk("hold_after fw_valid", 64'(fw_valid), 64'd0);

    // Reset while draining a discarded request
    drive(0, 0, 0, 1, 8'h55, 8'h00); step();
    drive(0, 0, 0, 0, 8'h00, 8'h00); #1;
    chk("drain imem_addr", 64'(imem_addr), 64'd0);
    chk("drain pc", 64'(pc), 64'h55);
    step();
    drive(1, 1, 0, 0, 8'h00, 8'h00); step();
    chk("drain_clr pc", 64'(pc), 64'd0);
    chk("drain_clr fw_valid", 64'(fw_valid), 64'd0);
    drive(0, 1, 0, 0, 8'h00, 8'h00); #1;
    chk("drain_after imem_req", 64'(imem_req), 64'd1);
    chk("drain_after imem_addr", 64'(imem_addr), 64'd0);
    step();
    chk("drain_after fw_valid", 64'(fw_valid), 64'd1);
    chk("drain_after fw_word", 64'(fw_word), 64'(word(8'h00)));
    chk("drain_after pc", 64'(pc), 64'd1);

    // Randomized traffic against the scoreboard model
    drive(1, 0, 0, 0, 8'h00, 8'h00); step();
    m_pc = 8'h00; m_held = 1'b0; m_drain = 1'b0; m_daddr = 8'h00;
    m_hword = '0; e_word = '0;
    for (int c = 0; c < 600; c++) begin
      s  = ($urandom_range(2) == 0);
      r  = ($urandom_range(7) == 0);
      rp = 8'($urandom);
      e_req  = !m_held;
      e_addr = m_drain ? m_daddr : m_pc;
      a = e_req && ($urandom_range(1) == 0);
      drive(0, a, s, r, rp, e_addr);
      #1;
      chk("rnd imem_req", 64'(imem_req), 64'(e_req));
      if (e_req) chk("rnd imem_addr", 64'(imem_addr), 64'(e_addr));

      // A redirect kills anything fetched but not yet delivered and
      // turns an unanswered request into one whose reply must be dropped.
      if (r) begin
        if (!m_held && !m_drain && !a) begin
          m_drain = 1'b1; m_daddr = m_pc;
        end else if (m_drain && a) begin
          m_drain = 1'b0;
        end
        m_held = 1'b0; m_pc = rp; e_valid = 1'b0;
      end else if (m_drain) begin
        if (a) m_drain = 1'b0;
        e_valid = 1'b0;
      end else if (m_held) begin
        e_valid = !s;
        if (!s) begin e_word = m_hword; m_held = 1'b0; end
      end else if (a) begin
        w = word(m_pc);
        m_pc = m_pc + 8'd1;
        if (s) begin m_held = 1'b1; m_hword = w; e_valid = 1'b0; end
        else begin e_valid = 1'b1; e_word = w; end
      end else begin
        e_valid = 1'b0;
      end

      step();
      chk("rnd fw_valid", 64'(fw_valid), 64'(e_valid));
      if (e_valid) chk("rnd fw_word", 64'(fw_word), 64'(e_word));
      chk("rnd pc", 64'(pc), 64'(m_pc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
